ps_detector: RTL and testbench
==============================

# ps_detector

Threshold-and-persistence detector that sits directly downstream of the power-sum feature stage. It consumes the 40-bit windowed power value and its valid flag, and decides when the feature has stayed above a programmable threshold for enough consecutive windows. It then asserts a detection flag, tracks the peak power during the event, and enforces a refractory holdoff before re-arming. Its outputs feed the system controller's event logic.

## Interface
Parameters:
- input_width, 40, width of the signed power value and of both thresholds
- cnt_width, 8, width of the event counter and the internal persistence/holdoff counters
- trig_count, 3, consecutive above-threshold samples required to declare detection (legal range 1..2^cnt_width-1)
- holdoff, 16, samples ignored after a detection ends (legal range 0..2^cnt_width-1)

Ports:
- clk, in, 1, single clock; all logic is rising-edge
- rst, in, 1, reset; synchronous and active-high; has priority over everything else
- en, in, 1, enable, active low; when en=1 all state and outputs hold
- din, in, input_width, signed power value from the upstream stage
- din_valid, in, 1, upstream valid; a sample is accepted on each edge where din_valid=1 and en=0
- thr_hi, in, input_width, signed entry threshold; sampled with each accepted sample
- thr_lo, in, input_width, signed exit threshold; used only when PS_DET_HYST_EN is defined
- detect, out, 1, level; high while in DETECT
- detect_pulse, out, 1, one-cycle strobe on entry to DETECT
- peak, out, input_width, signed maximum din seen during the current or most recent detection
- event_cnt, out, cnt_width, count of detections since reset, saturating at all-ones

## Operation
- States: IDLE, COUNT, DETECT, HOLDOFF. Transitions happen only on accepted samples. "Above" means din > thr_hi, a signed strict comparison.
- IDLE:
  - If above and trig_count==1: go to DETECT.
  - Else if above: go to COUNT with run=1.
  - Else: stay in IDLE.
- COUNT:
  - Above: run increments. When run+1 == trig_count, go to DETECT.
  - Not above: run clears and the state returns to IDLE.
- Entry to DETECT:
  - peak is loaded with the triggering din.
  - event_cnt increments unless it is all-ones.
  - detect_pulse is high for exactly one cycle.
- DETECT:
  - Each accepted sample updates peak to max(peak, din), signed.
  - Exit condition without the macro: din <= thr_hi. With the macro: see Configuration.
  - On exit: go to HOLDOFF with hcnt=holdoff. If holdoff==0, go directly to IDLE.
  - The exit sample does not update peak.
- HOLDOFF:
  - Comparisons are ignored.
  - Each accepted sample decrements hcnt. The sample that brings hcnt to 0 moves the state to IDLE.
  - The next sample after that is evaluated in IDLE.
- peak holds its value outside DETECT until the next detection entry.
- Thresholds are not latched. A thr_hi change takes effect on the next accepted sample.
- Reset values: state=IDLE, run=0, hcnt=0, detect=0, detect_pulse=0, peak=0, event_cnt=0.

## Timing
- All outputs are registered.
- detect and detect_pulse rise on the edge that accepts the triggering sample, and are visible in the following cycle.
- Latency from the first above sample is trig_count accepted samples.
- detect falls on the edge that accepts the exit sample.
- en=1 freezes the state machine, counters and outputs. detect_pulse is cleared on any edge that does not enter DETECT, including frozen cycles.
- din_valid=0 cycles with en=0 hold all state. Gaps do not break a COUNT run.
- rst asserted mid-event returns every register to its reset value on that edge. detect drops on that edge and no pulse is generated.
- Back-to-back accepted samples every cycle are supported. No backpressure to upstream.
- event_cnt saturates: once at all-ones, further detections still assert detect and detect_pulse, but the counter does not wrap.

## Configuration
- PS_DET_HYST_EN defined:
  - DETECT exits only when din < thr_lo (signed, strict).
  - Values between thr_lo and thr_hi keep DETECT active and update peak.
  - thr_lo > thr_hi is the user's responsibility. Exit then occurs whenever din < thr_lo.
- PS_DET_HYST_EN undefined:
  - thr_lo is ignored and unconnected internally.
  - DETECT exits when din <= thr_hi.

## Test plan
- Reset and persistence: after rst, all outputs are 0. With thr_hi=1000 and trig_count=3, feed 1001, 1001, 1001 on consecutive cycles.
  - detect=1 and detect_pulse=1 in the cycle after the 3rd sample.
  - peak=1001, event_cnt=1.
- Broken run: feed 1001, 1001, 999, 1001, 1001 with thr_hi=1000, trig_count=3. detect stays 0 and event_cnt stays 0.
- Holdoff: holdoff=4. Detect on 2000, 2000, 2000, then feed 500.
  - detect falls.
  - The next four samples of 2000 are ignored.
  - The 5th, 6th and 7th samples of 2000 re-detect, giving event_cnt=2.
- Peak and gaps: detect, then feed 1500, a din_valid=0 gap, 3000, 1200 with thr_hi=1000.
  - peak=3000.
  - The gap changes nothing.
  - en=1 for 5 cycles with din_valid=1 freezes all outputs.
- Hysteresis: PS_DET_HYST_EN defined, thr_hi=1000, thr_lo=600. In DETECT, feed 800 and 700: detect remains 1. Feed 599: detect drops.
  - Without the macro, 800 ends the detection.
- Reset mid-event and saturation:
  - rst during DETECT clears detect, peak and event_cnt on the next edge.
  - With cnt_width=2, four detections leave event_cnt=3, and detect_pulse still fires on the 4th.

Source files
------------

// File: rtl/ps_detector.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : ps_detector                                                    |
// | Brief   : Threshold/persistence detector with peak capture and holdoff;  |
// |           optional hysteresis exit selected by macro PS_DET_HYST_EN.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ps_detector #(
  parameter int input_width = 40,
  parameter int cnt_width   = 8,
  parameter int trig_count  = 3,
  parameter int holdoff     = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic signed [input_width-1:0] din,
  input  logic                          din_valid,
  input  logic signed [input_width-1:0] thr_hi,
  input  logic signed [input_width-1:0] thr_lo,
  output logic                          detect,
  output logic                          detect_pulse,
  output logic signed [input_width-1:0] peak,
  output logic        [cnt_width-1:0]   event_cnt
);

  localparam logic [1:0] C_IDLE    = 2'd0;
  localparam logic [1:0] C_COUNT   = 2'd1;
  localparam logic [1:0] C_DETECT  = 2'd2;
  localparam logic [1:0] C_HOLDOFF = 2'd3;

  localparam logic [cnt_width-1:0] C_ONE  = cnt_width'(1);
  localparam logic [cnt_width-1:0] C_TRIG = cnt_width'(trig_count);
  localparam logic [cnt_width-1:0] C_HOLD = cnt_width'(holdoff);

  logic [1:0]                   state_q, state_d;
  logic [cnt_width-1:0]         run_q, run_d;
  logic [cnt_width-1:0]         hcnt_q, hcnt_d;
  logic                         detect_q, detect_d;
  logic                         pulse_q, pulse_d;
  logic signed [input_width-1:0] peak_q, peak_d;
  logic [cnt_width-1:0]         cnt_q, cnt_d;

  logic w_accept;
  logic w_above;
  logic w_exit;
  logic w_enter;

  assign w_accept = din_valid && !en;
  assign w_above  = din > thr_hi;

`ifdef PS_DET_HYST_EN
  assign w_exit = din < thr_lo;
`else
  logic unused_thr_lo;
  assign unused_thr_lo = ^thr_lo;
  assign w_exit        = !w_above;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= C_IDLE;
      run_q    <= '0;
      hcnt_q   <= '0;
      detect_q <= 1'b0;
      pulse_q  <= 1'b0;
      peak_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      hcnt_q   <= hcnt_d;
      detect_q <= detect_d;
      pulse_q  <= pulse_d;
      peak_q   <= peak_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    hcnt_d  = hcnt_q;
    if (w_accept) begin
      case (state_q)
        C_IDLE: begin
          if (w_above) begin
            if (trig_count == 1) begin
              state_d = C_DETECT;
            end else begin
              state_d = C_COUNT;
              run_d   = C_ONE;
            end
          end
        end
        C_COUNT: begin
          if (w_above) begin
            if (run_q + C_ONE == C_TRIG) begin
              state_d = C_DETECT;
              run_d   = '0;
            end else begin
              run_d = run_q + C_ONE;
            end
          end else begin
            state_d = C_IDLE;
            run_d   = '0;
          end
        end
        C_DETECT: begin
          if (w_exit) begin
            if (holdoff == 0) begin
              state_d = C_IDLE;
            end else begin
              state_d = C_HOLDOFF;
              hcnt_d  = C_HOLD;
            end
          end
        end
        default: begin
          // Guard against hcnt already at zero so it can never wrap.
          hcnt_d = (hcnt_q == '0) ? '0 : hcnt_q - C_ONE;
          if (hcnt_q <= C_ONE) state_d = C_IDLE;
        end
      endcase
    end
  end

  assign w_enter = w_accept && (state_d == C_DETECT) && (state_q != C_DETECT);

  always_comb begin
    detect_d = (state_d == C_DETECT);
    pulse_d  = w_enter;
    peak_d   = peak_q;
    cnt_d    = cnt_q;
    if (w_enter) begin
      peak_d = din;
      if (cnt_q != '1) cnt_d = cnt_q + C_ONE;
    end else if (w_accept && (state_q == C_DETECT) && (state_d == C_DETECT) && (din > peak_q)) begin
      peak_d = din;
    end
  end

  assign detect       = detect_q;
  assign detect_pulse = pulse_q;
  assign peak         = peak_q;
  assign event_cnt    = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ps_detector.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_ps_detector                                                 |
// | Brief   : Directed scoreboard bench for ps_detector (two configurations). |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_ps_detector;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic din_valid = 1'b0;
  logic signed [39:0] din = '0;
  logic signed [39:0] thr_hi = 40'sd1000;
  logic signed [39:0] thr_lo = 40'sd600;

  logic               det_a, pul_a, det_b, pul_b;
  logic signed [39:0] peak_a, peak_b;
  logic [7:0]         cnt_a;
  logic [1:0]         cnt_b;

  int total = 0;
  int bad = 0;
  int step_no = 0;

  typedef struct {
    bit                 which;
    int                 idx;
    bit                 det;
    bit                 pul;
    logic signed [39:0] pk;
    logic [39:0]        cnt;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  ps_detector #(.input_width(40), .cnt_width(8), .trig_count(3), .holdoff(4)) dut_a (
    .clk(clk), .rst(rst), .en(en), .din(din), .din_valid(din_valid),
    .thr_hi(thr_hi), .thr_lo(thr_lo), .detect(det_a), .detect_pulse(pul_a),
    .peak(peak_a), .event_cnt(cnt_a)
  );

  ps_detector #(.input_width(40), .cnt_width(2), .trig_count(1), .holdoff(0)) dut_b (
    .clk(clk), .rst(rst), .en(en), .din(din), .din_valid(din_valid),
    .thr_hi(thr_hi), .thr_lo(thr_lo), .detect(det_b), .detect_pulse(pul_b),
    .peak(peak_b), .event_cnt(cnt_b)
  );

  task automatic chk(input string nm, input int idx, input logic [39:0] act, input logic [39:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s step %0d: got %0d want %0d", nm, idx, $signed(act), $signed(want));
    end
  endtask

  // Every driven cycle pushes the register state expected after the next edge.
  task automatic step(input bit r, input bit v, input bit e,
                      input logic signed [39:0] d, input logic signed [39:0] th,
                      input logic signed [39:0] tl, input bit w,
                      input bit xd, input bit xp, input logic signed [39:0] xpk, input int xc);
    exp_t x;
    @(negedge clk);
    rst = r; din_valid = v; en = e; din = d; thr_hi = th; thr_lo = tl;
    x.which = w; x.idx = step_no; x.det = xd; x.pul = xp; x.pk = xpk; x.cnt = 40'(xc);
    sb.push_back(x);
    step_no++;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (!e.which) begin
          chk("detect_a", e.idx, 40'(det_a), 40'(e.det));
          chk("pulse_a",  e.idx, 40'(pul_a), 40'(e.pul));
          chk("peak_a",   e.idx, peak_a, e.pk);
          chk("cnt_a",    e.idx, 40'(cnt_a), e.cnt);
        end else begin
          chk("detect_b", e.idx, 40'(det_b), 40'(e.det));
          chk("pulse_b",  e.idx, 40'(pul_b), 40'(e.pul));
          chk("peak_b",   e.idx, peak_b, e.pk);
          chk("cnt_b",    e.idx, 40'(cnt_b), e.cnt);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : driver
    // reset
    step(1, 0, 0, 0, 1000, 600, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1000, 600, 1, 0, 0, 0, 0);
    // broken run never detects
    step(0, 1, 0, 1001, 1000, 600, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1001, 1000, 600, 0, 0, 0, 0, 0);
    step(0, 1, 0,  999, 1000, 600, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1001, 1000, 600, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1001, 1000, 600, 0, 0, 0, 0, 0);
    step(0, 1, 0,  999, 1000, 600, 0, 0, 0, 0, 0);
    // persistence
    step(0, 1, 0, 1001, 1000, 600, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1001, 1000, 600, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1001, 1000, 600, 0, 1, 1, 1001, 1);
    // peak tracking across a valid gap
    step(0, 1, 0, 1500, 1000, 600, 0, 1, 0, 1500, 1);
    step(0, 0, 0, 9999, 1000, 600, 0, 1, 0, 1500, 1);
    step(0, 1, 0, 3000, 1000, 600, 0, 1, 0, 3000, 1);
    step(0, 1, 0, 1200, 1000, 600, 0, 1, 0, 3000, 1);
    // freeze
    step(0, 1, 1, 5000, 1000, 600, 0, 1, 0, 3000, 1);
    step(0, 1, 1,    0, 1000, 600, 0, 1, 0, 3000, 1);
    step(0, 1, 1, 5000, 1000, 600, 0, 1, 0, 3000, 1);
    step(0, 1, 1,    0, 1000, 600, 0, 1, 0, 3000, 1);
    step(0, 1, 1, 5000, 1000, 600, 0, 1, 0, 3000, 1);
    // exit behaviour
`ifdef PS_DET_HYST_EN
    step(0, 1, 0,  800, 1000, 600, 0, 1, 0, 3000, 1);
    step(0, 1, 0,  700, 1000, 600, 0, 1, 0, 3000, 1);
    step(0, 1, 0,  599, 1000, 600, 0, 0, 0, 3000, 1);
`else
    step(0, 1, 0,  800, 1000, 600, 0, 0, 0, 3000, 1);
`endif
    // holdoff ignores four samples, then re-arms
    for (int i = 0; i < 6; i++) step(0, 1, 0, 2000, 1000, 600, 0, 0, 0, 3000, 1);
    step(0, 1, 0, 2000, 1000, 600, 0, 1, 1, 2000, 2);
    step(0, 1, 0,  500, 1000, 600, 0, 0, 0, 2000, 2);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 2000, 1000, 600, 0, 0, 0, 2000, 2);
    step(0, 1, 0, 2000, 1000, 600, 0, 1, 1, 2000, 3);
    step(0, 1, 0, 2500, 1000, 600, 0, 1, 0, 2500, 3);
    // reset mid-event
    step(1, 1, 0, 9000, 1000, 600, 0, 0, 0, 0, 0);
    // saturation on the 2-bit counter instance
    step(0, 1, 0, 2000, 1000, 600, 1, 1, 1, 2000, 1);
    step(0, 1, 0,  500, 1000, 600, 1, 0, 0, 2000, 1);
    step(0, 1, 0, 2100, 1000, 600, 1, 1, 1, 2100, 2);
    step(0, 1, 0,  500, 1000, 600, 1, 0, 0, 2100, 2);
    step(0, 1, 0, 2200, 1000, 600, 1, 1, 1, 2200, 3);
    step(0, 1, 0,  500, 1000, 600, 1, 0, 0, 2200, 3);
    step(0, 1, 0, 2300, 1000, 600, 1, 1, 1, 2300, 3);
    step(0, 1, 0, 2400, 1000, 600, 1, 1, 0, 2400, 3);
    // signed threshold and signed peak
    step(0, 1, 0, -200, -100, -150, 1, 0, 0, 2400, 3);
    step(0, 1, 0,    5, -100, -150, 1, 1, 1, 5, 3);
    step(0, 1, 0,  -20, -100, -150, 1, 1, 0, 5, 3);
    @(negedge clk);
    din_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
